one_unit_iter_controller: RTL and testbench

- Outer-loop sequencer for the one-unit FastICA datapath.
- Per component: requests weight init, then runs fast passes (mul/mean/sub pipeline via the fast controller's go_fast/fast_busy) until converged or the iteration limit is hit.
- Each pass is followed by a decorrelation/normalization step and a convergence check.
- After N_COMP components it pulses done.

---
 rtl/one_unit_iter_controller.sv | 137 +++++++++++++
 tb/tb_one_unit_iter_controller.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/one_unit_iter_controller.sv
// Outer-loop sequencer for one-unit FastICA: per component runs weight init, then
// fast pass / decorrelation / convergence check until converged or MAX_ITER passes, then stores.
module one_unit_iter_controller #(
    parameter int N_COMP   = 4,
    parameter int COMP_W   = 2,
    parameter int MAX_ITER = 100
) (
    input  logic              clk_fast,
    input  logic              rst,
    input  logic              start,
    input  logic              fast_busy,
    input  logic              decor_done,
    input  logic              conv_valid,
    input  logic              conv_ok,
    output logic              go_fast,
    output logic              en_winit,
    output logic              en_decor,
    output logic              en_conv,
    output logic              en_store,
    output logic              store_timeout,
    output logic [COMP_W-1:0] comp_idx,
    output logic [7:0]        iter_cnt,
    output logic              busy,
    output logic              done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WINIT,
        S_FAST,
        S_FAST_END,
        S_DECOR_REQ,
        S_DECOR_WAIT,
        S_CONV_REQ,
        S_CONV_WAIT,
        S_STORE,
        S_DONE
    } state_t;

    localparam logic [7:0]        LAST_ITER = 8'(MAX_ITER - 1);
    localparam logic [COMP_W-1:0] LAST_COMP = COMP_W'(N_COMP - 1);

    state_t            state_q, state_d;
    logic [COMP_W-1:0] comp_idx_q, comp_idx_d;
    logic [7:0]        iter_cnt_q, iter_cnt_d;
    logic              seen_busy_q, seen_busy_d;
    logic              tmo_q, tmo_d;

    always_comb begin
        state_d     = state_q;
        comp_idx_d  = comp_idx_q;
        iter_cnt_d  = iter_cnt_q;
        seen_busy_d = seen_busy_q;
        tmo_d       = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_WINIT;
                    comp_idx_d = '0;
                    iter_cnt_d = '0;
                end
            end
            S_WINIT: begin
                state_d     = S_FAST;
                seen_busy_d = 1'b0;
            end
            S_FAST: begin
                // The fast controller spends a cycle in INIT with busy low; only a
                // falling busy after it was seen high marks the end of a pass.
                seen_busy_d = seen_busy_q | fast_busy;
                if (seen_busy_q && !fast_busy) begin
                    state_d = S_FAST_END;
                end
            end
            S_FAST_END:   state_d = S_DECOR_REQ;
            S_DECOR_REQ:  state_d = S_DECOR_WAIT;
            S_DECOR_WAIT: begin
                if (decor_done) begin
                    state_d = S_CONV_REQ;
                end
            end
            S_CONV_REQ:   state_d = S_CONV_WAIT;
            S_CONV_WAIT: begin
                if (conv_valid) begin
                    if (conv_ok || (iter_cnt_q == LAST_ITER)) begin
                        state_d = S_STORE;
                        tmo_d   = ~conv_ok;
                    end else begin
                        state_d     = S_FAST;
                        iter_cnt_d  = iter_cnt_q + 8'd1;
                        seen_busy_d = 1'b0;
                    end
                end
            end
            S_STORE: begin
                iter_cnt_d = '0;
                if (comp_idx_q == LAST_COMP) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = S_WINIT;
                    comp_idx_d = comp_idx_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            state_q     <= S_IDLE;
            comp_idx_q  <= '0;
            iter_cnt_q  <= '0;
            seen_busy_q <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            comp_idx_q  <= comp_idx_d;
            iter_cnt_q  <= iter_cnt_d;
            seen_busy_q <= seen_busy_d;
            tmo_q       <= tmo_d;
        end
    end

    // Outputs depend only on registered state, so they are clean for the cycle.
    assign go_fast       = (state_q == S_FAST);
    assign en_winit      = (state_q == S_WINIT);
    assign en_decor      = (state_q == S_DECOR_REQ);
    assign en_conv       = (state_q == S_CONV_REQ);
    assign en_store      = (state_q == S_STORE);
    assign store_timeout = (state_q == S_STORE) && tmo_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign comp_idx      = comp_idx_q;
    assign iter_cnt      = iter_cnt_q;

endmodule

// File: tb/tb_one_unit_iter_controller.sv
// Bench for one_unit_iter_controller: behavioural fast/decor/conv responders, a table of
// per-component scenarios feeding a store scoreboard, and hand-written mid-run resets.
module tb_one_unit_iter_controller;

    localparam int N_COMP    = 4;
    localparam int COMP_W    = 2;
    localparam int MAX_ITER  = 3;
    localparam int FAST_INIT = 2;
    localparam int FAST_BUSY = 134;
    localparam int CONV_DLY  = 2;

    logic clk, rst, start, fast_busy, decor_done, conv_valid, conv_ok;
    logic go_fast, en_winit, en_decor, en_conv, en_store, store_timeout, busy, done;
    logic [COMP_W-1:0] comp_idx;
    logic [7:0] iter_cnt;

    one_unit_iter_controller #(.N_COMP(N_COMP), .COMP_W(COMP_W), .MAX_ITER(MAX_ITER)) dut (
        .clk_fast(clk), .rst(rst), .start(start), .fast_busy(fast_busy),
        .decor_done(decor_done), .conv_valid(conv_valid), .conv_ok(conv_ok),
        .go_fast(go_fast), .en_winit(en_winit), .en_decor(en_decor), .en_conv(en_conv),
        .en_store(en_store), .store_timeout(store_timeout), .comp_idx(comp_idx),
        .iter_cnt(iter_cnt), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // conv_pass: pass index on which conv_ok is reported (-1 = never)
    typedef struct {
        int         conv_pass;
        int         decor_dly;
        bit         strays;
        logic [1:0] exp_comp;
        logic [7:0] exp_iter;
        bit         exp_tmo;
        int         exp_passes;
    } vec_t;

    typedef struct {
        logic [1:0] comp;
        logic [7:0] iter;
        bit         tmo;
        int         passes;
    } exp_t;

    vec_t tbl[8];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit env_on = 0;
    int row_base, comp_m, pass_m, fcnt, dcnt, ccnt, windows;
    int t_start, t_winit, t_gorise, t_gofall, t_decor, t_valid, t_store, t_done;
    int done_cnt, store_cnt;
    logic prev_go = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] out_vec();
        return {go_fast, en_winit, en_decor, en_conv, en_store, store_timeout, busy, done};
    endfunction

    function automatic int cur_row();
        return row_base + ((comp_m < 0) ? 0 : comp_m);
    endfunction

    task automatic quiet_inputs();
        fast_busy  = 1'b0;
        decor_done = 1'b0;
        conv_valid = 1'b0;
        conv_ok    = 1'b0;
    endtask

    task automatic env_reset();
        comp_m = -1; pass_m = 0; fcnt = 0; dcnt = -1; ccnt = -1; windows = 0;
        t_start = -100; t_winit = -100; t_gorise = -100; t_gofall = -100;
        t_decor = -100; t_valid = -100; t_store = -100; t_done = -100;
        done_cnt = 0; store_cnt = 0;
        sb.delete();
        prev_go = 1'b0;
        quiet_inputs();
    endtask

    task automatic monitor();
        exp_t e;
        if (en_winit) begin
            if (comp_m < 0) check("winit_after_start", cyc - t_start, 1);
            else            check("winit_after_store", cyc - t_store, 1);
            comp_m++; pass_m = 0; windows = 0; t_winit = cyc;
            check("winit_comp_idx", 32'(comp_idx), comp_m);
            check("winit_iter_cnt", 32'(iter_cnt), 0);
        end
        if (go_fast && !prev_go) begin
            t_gorise = cyc; windows++;
            check("pass_iter_cnt", 32'(iter_cnt), pass_m);
            if (pass_m > 0) check("conv_to_fast_latency", cyc - t_valid, 1);
            else            check("winit_to_fast_latency", cyc - t_winit, 1);
        end
        if (!go_fast && prev_go) begin
            t_gofall = cyc;
            check("fast_window_len", cyc - t_gorise, FAST_INIT + FAST_BUSY + 1);
        end
        if (en_decor) begin
            check("fast_end_to_decor", cyc - t_gofall, 1);
            t_decor = cyc;
        end
        if (en_conv) check("decor_to_conv", cyc - t_decor, tbl[cur_row()].decor_dly + 1);
        if (en_store) begin
            store_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_store: comp_idx %0d iter_cnt %0d with no store expected (cycle %0d)",
                         comp_idx, iter_cnt, cyc);
            end else begin
                e = sb.pop_front();
                check("store_comp_idx", 32'(comp_idx), 32'(e.comp));
                check("store_iter_cnt", 32'(iter_cnt), 32'(e.iter));
                check("store_timeout", 32'(store_timeout), 32'(e.tmo));
                check("store_passes", windows, e.passes);
                check("conv_to_store_latency", cyc - t_valid, 1);
            end
            t_store = cyc;
        end
        if (done) begin
            done_cnt++;
            check("store_to_done", cyc - t_store, 1);
            check("done_comp_idx", 32'(comp_idx), N_COMP - 1);
            t_done = cyc;
        end
        if (cyc == t_done + 1) check("busy_after_done", 32'(busy), 0);
    endtask

    task automatic respond();
        int r;
        r = cur_row();
        if (go_fast) fcnt++;
        else         fcnt = 0;
        fast_busy = go_fast && (fcnt > FAST_INIT) && (fcnt <= FAST_INIT + FAST_BUSY);
        // a stray decor_done during DECOR_REQ must not be sampled
        decor_done = 1'b0;
        if (en_decor) begin
            dcnt = 0;
            if (tbl[r].strays) decor_done = 1'b1;
        end else if (dcnt >= 0) begin
            dcnt++;
            if (dcnt == tbl[r].decor_dly) begin
                decor_done = 1'b1;
                dcnt = -1;
            end
        end
        conv_valid = 1'b0;
        conv_ok    = 1'b0;
        if (en_conv) begin
            ccnt = 0;
        end else if (ccnt >= 0) begin
            ccnt++;
            if (ccnt == CONV_DLY) begin
                conv_valid = 1'b1;
                conv_ok    = (pass_m == tbl[r].conv_pass);
                t_valid    = cyc;
                ccnt       = -1;
                pass_m++;
            end else if (tbl[r].strays) begin
                conv_ok = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (env_on) begin
            monitor();
            respond();
        end
        prev_go = go_fast;
    endtask

    task automatic run(input int base);
        bit fin;
        env_reset();
        row_base = base;
        env_on = 1;
        for (int i = 0; i < N_COMP; i++) begin
            sb.push_back('{comp: tbl[base+i].exp_comp, iter: tbl[base+i].exp_iter,
                           tmo: tbl[base+i].exp_tmo, passes: tbl[base+i].exp_passes});
        end
        start = 1'b1; t_start = cyc;
        step();
        start = 1'b0;
        fin = 0;
        for (int i = 0; i < 20000 && !fin; i++) begin
            start = (i == 300);
            step();
            if (done_cnt > 0) fin = 1;
        end
        start = 1'b0;
        check("run_completes", 32'(fin), 1);
        step();
        check("stores_per_run", store_cnt, N_COMP);
        check("done_per_run", done_cnt, 1);
        check("scoreboard_drained", sb.size(), 0);
        env_on = 0;
    endtask

    task automatic abort_run(input int which);
        bit hit;
        env_reset();
        row_base = 4;
        env_on = 1;
        start = 1'b1; t_start = cyc;
        step();
        start = 1'b0;
        hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            step();
            if (which == 0 && go_fast && fcnt == 10) hit = 1;
            if (which == 1 && en_conv && pass_m == 1) hit = 1;
        end
        if (which == 1 && hit) step();
        check("abort_point_reached", 32'(hit), 1);
        if (which == 0) check("pre_rst_go_fast", 32'(go_fast), 1);
        else            check("pre_rst_iter_cnt", 32'(iter_cnt), 1);
        env_on = 0;
        quiet_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_outputs", 32'(out_vec()), 0);
        check("mid_rst_comp_idx", 32'(comp_idx), 0);
        check("mid_rst_iter_cnt", 32'(iter_cnt), 0);
        step();
        check("post_rst_idle_outputs", 32'(out_vec()), 0);
        check("abort_no_store", store_cnt, 0);
        check("abort_no_done", done_cnt, 0);
    endtask

    initial begin
        // run 1: mixed convergence, timeout, converge-on-last-pass, stray handshakes
        tbl[0] = '{conv_pass: 0,  decor_dly: 3, strays: 0, exp_comp: 2'd0, exp_iter: 8'd0, exp_tmo: 0, exp_passes: 1};
        tbl[1] = '{conv_pass: -1, decor_dly: 1, strays: 1, exp_comp: 2'd1, exp_iter: 8'd2, exp_tmo: 1, exp_passes: 3};
        tbl[2] = '{conv_pass: 2,  decor_dly: 2, strays: 1, exp_comp: 2'd2, exp_iter: 8'd2, exp_tmo: 0, exp_passes: 3};
        tbl[3] = '{conv_pass: 1,  decor_dly: 3, strays: 0, exp_comp: 2'd3, exp_iter: 8'd1, exp_tmo: 0, exp_passes: 2};
        // run 2: every component converges on its second pass
        tbl[4] = '{conv_pass: 1,  decor_dly: 3, strays: 0, exp_comp: 2'd0, exp_iter: 8'd1, exp_tmo: 0, exp_passes: 2};
        tbl[5] = '{conv_pass: 1,  decor_dly: 3, strays: 1, exp_comp: 2'd1, exp_iter: 8'd1, exp_tmo: 0, exp_passes: 2};
        tbl[6] = '{conv_pass: 1,  decor_dly: 2, strays: 0, exp_comp: 2'd2, exp_iter: 8'd1, exp_tmo: 0, exp_passes: 2};
        tbl[7] = '{conv_pass: 1,  decor_dly: 4, strays: 1, exp_comp: 2'd3, exp_iter: 8'd1, exp_tmo: 0, exp_passes: 2};

        env_reset();
        rst = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("reset_outputs", 32'(out_vec()), 0);
            check("reset_comp_idx", 32'(comp_idx), 0);
            check("reset_iter_cnt", 32'(iter_cnt), 0);
        end
        rst = 1'b0;
        start = 1'b0;
        step();
        check("idle_after_reset", 32'(out_vec()), 0);

        run(0);
        run(4);
        abort_run(0);
        abort_run(1);
        run(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
